grant_decoder_seq: RTL

- Sequential 3:8 decoder; the inverse of the team's 8:3 priority encoder.
- Accepts an encoded index via a valid/ready handshake and drives the matching one-hot line for a programmable number of cycles, or until early release.
- Enforces one dead cycle between grants.
- Sits downstream of the priority encoder to turn an encoded winner back into a one-hot grant/enable bus.

---
 rtl/grant_dec_pkg.sv | 25 ++
 rtl/onehot_dec.sv | 23 ++
 rtl/grant_decoder_seq.sv | 121 ++++++++++++
 3 files changed

// File: rtl/grant_dec_pkg.sv
// Shared types and defaults for the sequential grant decoder.
// The optional grant statistics counter is enabled by defining GRANT_DECODER_STATS_EN.
package grant_dec_pkg;

  // Default geometry and timing
  localparam int unsigned N_OUT_DEF  = 8;
  localparam int unsigned HOLD_DEF   = 4;
  localparam int unsigned HOLD_W_DEF = 8;

  // Width of the optional accepted-grant counter
  localparam int unsigned STATS_W = 16;

  // Grant sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Saturating increment for the statistics counter
  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    return (v == '1) ? v : v + STATS_W'(1);
  endfunction

endpackage : grant_dec_pkg

// File: rtl/onehot_dec.sv
// Combinational index-to-one-hot decoder with an in-range flag.
// Indices at or above N_OUT produce an all-zero vector and a cleared flag.
module onehot_dec
  import grant_dec_pkg::*;
#(
  parameter  int unsigned N_OUT = N_OUT_DEF,
  localparam int unsigned IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic [IDX_W-1:0] i_idx,
  output logic [N_OUT-1:0] o_onehot_c,
  output logic             o_in_range_c
);

  // Decode every line independently so out-of-range indices light nothing
  always_comb begin
    o_onehot_c   = '0;
    o_in_range_c = ({1'b0, i_idx} < (IDX_W + 1)'(N_OUT));
    for (int unsigned i = 0; i < N_OUT; i++) begin
      o_onehot_c[i] = (i_idx == IDX_W'(i));
    end
  end

endmodule : onehot_dec

// File: rtl/grant_decoder_seq.sv
// Sequential 3:8 grant decoder: accepts an encoded winner over valid/ready,
// holds the matching one-hot line for HOLD cycles (or until early release),
// then inserts one dead cycle before the next grant.
// Optional macro GRANT_DECODER_STATS_EN adds a saturating accepted-grant counter.
module grant_decoder_seq
  import grant_dec_pkg::*;
#(
  parameter  int unsigned N_OUT  = N_OUT_DEF,
  parameter  int unsigned HOLD   = HOLD_DEF,
  parameter  int unsigned HOLD_W = HOLD_W_DEF,
  localparam int unsigned IDX_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [IDX_W-1:0]   i_in_idx,
  input  logic               i_release,
  output logic [N_OUT-1:0]   o_y,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err
`ifdef GRANT_DECODER_STATS_EN
  ,
  output logic [STATS_W-1:0] o_grant_cnt
`endif
);

  state_t             r_state;
  logic [HOLD_W-1:0]  r_cnt;
  logic [N_OUT-1:0]   r_y;
  logic               r_busy;
  logic               r_done;
  logic               r_err;

  logic [N_OUT-1:0]   w_onehot;
  logic               w_in_range;
  logic               w_accept;
  logic               w_hold_end;

  onehot_dec #(
    .N_OUT (N_OUT)
  ) u_onehot_dec (
    .i_idx        (i_in_idx),
    .o_onehot_c   (w_onehot),
    .o_in_range_c (w_in_range)
  );

  // Ready is a pure decode of the state register, so it carries no input path
  assign o_in_ready = (r_state == ST_IDLE);
  assign w_accept   = i_in_valid && (r_state == ST_IDLE);
  assign w_hold_end = (r_cnt == '0) || i_release;

  // Grant sequencer: IDLE accepts, HOLD drives the line, GAP is the dead cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_y     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_in_range) begin
              r_y     <= w_onehot;
              r_busy  <= 1'b1;
              r_cnt   <= HOLD_W'(HOLD - 1);
              r_state <= ST_HOLD;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (w_hold_end) begin
            r_y     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_GAP;
          end else begin
            r_cnt <= r_cnt - HOLD_W'(1);
          end
        end
        ST_GAP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_y     <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_y    = r_y;
  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_err  = r_err;

`ifdef GRANT_DECODER_STATS_EN
  logic [STATS_W-1:0] r_grant_cnt;

  // Count in-range accepted handshakes, saturating at all-ones
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_grant_cnt <= '0;
    end else if (w_accept && w_in_range) begin
      r_grant_cnt <= sat_inc(r_grant_cnt);
    end
  end

  assign o_grant_cnt = r_grant_cnt;
`endif

endmodule : grant_decoder_seq
